// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the RegFile write port.
// Round-robin grant between ALU and load requesters, plus a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WD,
  output logic              RorW
);

  logic              ptr;
  logic              xfer0_p0;
  logic              xfer1_p0;
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [NREG-1:0]   busy_nxt;

  // Stage p0: grant and select; the two grants are mutually exclusive by construction.
  assign req0_ready = !req1_valid || !ptr;
  assign req1_ready = !req0_valid || ptr;
  assign xfer0_p0   = req0_valid && req0_ready;
  assign xfer1_p0   = req1_valid && req1_ready;
  assign addr_p0    = xfer1_p0 ? req1_addr : req0_addr;
  assign data_p0    = xfer1_p0 ? req1_data : req0_data;
  assign vld_p0     = (xfer0_p0 || xfer1_p0) && (addr_p0 != '0);

  always_comb begin
    busy_nxt = busy_vec;
    if (RorW)
      busy_nxt[WriteReg] = 1'b0;
    if (claim_valid && (claim_addr != '0))
      busy_nxt[claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered RegFile write port, round-robin pointer and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      RorW     <= 1'b0;
      WriteReg <= '0;
      WD       <= '0;
      busy_vec <= '0;
    end else begin
      if (req0_valid && req1_valid)
        ptr <= !ptr;
      RorW <= vld_p0;
      if (vld_p0) begin
        WriteReg <= addr_p0;
        WD       <= data_p0;
      end
      busy_vec <= busy_nxt;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of RegFile (WriteReg / WD / RorW) and shares it between two writeback requesters: req0 (ALU result) and req1 (memory load).
- Grants at most one write per cycle using round-robin on conflict. The granted write is registered onto the RegFile write port one cycle later.
- Keeps a per-register busy scoreboard. Issue logic sets a bit with a claim; the bit clears when the matching write commits. Decode uses busy_vec to stall on RAW hazards.

Parameters:
ADDR_W, 5, register address width (RegFile A1/A2/WriteReg width)
DATA_W, 32, register data width (WD/RD width)
NREG, 2**ADDR_W, number of architectural registers (width of busy_vec)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  ALU writeback request
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  req0 granted this cycle
req1_valid  in  1  load writeback request
req1_addr  in  ADDR_W  load destination register
req1_data  in  DATA_W  load data
req1_ready  out  1  req1 granted this cycle
claim_valid  in  1  issue stage reserves a destination register
claim_addr  in  ADDR_W  register being reserved
busy_vec  out  NREG  bit k=1: a write to register k is outstanding
WriteReg  out  ADDR_W  to RegFile WriteReg, registered
WD  out  DATA_W  to RegFile WD, registered
RorW  out  1  to RegFile RorW (1 = write), registered

Behaviour:
- Reset (rst_n low, asynchronous): WriteReg=0, WD=0, RorW=0, busy_vec=0, round-robin pointer ptr=0 (req0 favoured). Reset mid-transfer drops the pending registered write; RorW is 0 immediately.
- Ready is combinational and does not depend on the requester's own valid:
  - req0_ready = !req1_valid || (ptr==0)
  - req1_ready = !req0_valid || (ptr==1)
- Transfer on reqX = reqX_valid && reqX_ready at a rising edge. At most one transfer per cycle, always.
- ptr toggles only on a conflict (both valid), to favour the loser next cycle. A lone request leaves ptr unchanged.
- Output register, loaded every edge:
  - On a transfer to a nonzero address: WriteReg=addr, WD=data, RorW=1.
  - Otherwise: RorW=0. WriteReg and WD hold their last value.
- A transfer to register 0 completes the handshake but yields RorW=0 (the $zero write is discarded).
- Latency: request accepted at edge N; RorW=1 during cycle N to N+1; RegFile commits at edge N+1. Throughput is one write per cycle.
- Scoreboard, updated at each edge:
  - Clear: if RorW==1, clear busy_vec[WriteReg]. The clear happens at commit, not at acceptance.
  - Set: if claim_valid && claim_addr!=0, set busy_vec[claim_addr].
  - Set and clear of the same bit in one edge: set wins.
  - Claiming an already-busy register: bit stays 1, no error.
  - busy_vec[0] is constant 0.
- A write to a register that is not busy is legal. It commits normally and busy is unaffected.
- Requesters must hold addr/data stable while valid && !ready. No internal queueing; a waiting requester simply stalls.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> WriteReg=0, WD=0, RorW=0, busy_vec=0 immediately. Hold req0_valid=1 during reset -> no write issued.
- Single write: req0 addr=10, data=256 for 1 cycle -> req0_ready=1; next cycle RorW=1, WriteReg=10, WD=256; following cycle RorW=0. RegFile RD1 with A1=10 reads 256.
- Conflict: req0 (11, 65535) and req1 (12, 0xDEADBEEF) held valid -> req0 granted first (ptr=0), req1 granted next cycle. RorW=1 for two consecutive cycles, WriteReg 11 then 12. A second conflict grants req1 first.
- $zero: req1 addr=0, data=5 -> req1_ready=1, RorW stays 0, RegFile register 0 reads 0.
- Scoreboard: claim 10 at edge N -> busy_vec[10]=1. Write to 10 accepted at N+2 -> busy_vec[10] clears after edge N+3. Claim 10 again on the commit edge -> busy_vec[10] stays 1.
- Claim 0 -> busy_vec stays 0. Back-to-back lone req0 writes on 8 cycles -> ptr unchanged, 8 consecutive RorW=1 cycles.
